d_cfir_coe_sequencer: RTL
=========================

// Module: d_cfir_coe_sequencer
// PURPOSE
//  Configures the D-CFIR slave array. Takes a 6-coefficient update request (3 real + 3 imag, 10b each) over a valid/ready port.
//  Serialises it as 23b words on the shared sdi bus, strobing the target slave's ssb per word.
//  Then pulses that slave's coe_load and updates its sel in the same cycle. One update in flight at a time.
// PARAMETERS
//  NUM_SLAVES  4   number of D-CFIR slaves driven (1..16)
//  COE_W       10  coefficient width (sdi format below assumes 10)
//  GAP_CYCLES  1   idle cycles (ssb high) after each sdi word (>=1)
// PORTS
//  CLK        in   1             clock, all logic on posedge
//  rst        in   1             synchronous reset, active low
//  cfg_valid  in   1             update request valid
//  cfg_ready  out  1             = (state==IDLE) & rst & !abort
//  cfg_slave  in   4             target slave index
//  cfg_coe    in   6*COE_W       [9:0]=re0 [19:10]=re1 [29:20]=re2 [39:30]=im0 [49:40]=im1 [59:50]=im2
//  cfg_sel    in   6             new sel for target slave
//  abort      in   1             cancel in-flight update
//  ssb        out  NUM_SLAVES    per-slave word strobe, active low
//  sdi        out  23            shared word bus
//  coe_load   out  NUM_SLAVES    per-slave one-cycle load pulse
//  sel_o      out  6*NUM_SLAVES  per-slave sel, slave i at [6i+5:6i]
//  done       out  1             one-cycle completion pulse
//  err        out  1             high with done when cfg_slave >= NUM_SLAVES
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; ssb all 1; sdi=0; coe_load=0; sel_o=0; done=0; err=0; latched request cleared.
//  All outputs are registered except cfg_ready.
//  Accept: cfg_valid & cfg_ready at edge T latches slave, coe, sel. Inputs are ignored at all other times.
//  sdi word = {slave[3:0], idx[2:0], 6'b0, coe[9:0]}.
//    idx 0..5 = re0,re1,re2,im0,im1,im2, sent in that order.
//  States: IDLE -> WORD -> GAP (x GAP_CYCLES) -> WORD ... (6 words) -> LOAD -> DONE -> IDLE.
//  WORD k is visible in cycle T+1+k*(1+GAP_CYCLES).
//    During WORD: ssb[slave]=0, other ssb bits 1, sdi=word.
//    During GAP: all ssb=1, sdi=0.
//  LOAD cycle T+1+6*(1+GAP_CYCLES): coe_load[slave]=1 and sel_o[slave] takes cfg_sel in that same cycle.
//  DONE: done=1 in the next cycle. cfg_ready rises the cycle after that.
//    Defaults: LOAD T+13, done T+14, ready T+15.
//  Bad slave (>= NUM_SLAVES): the request is accepted. IDLE -> DONE directly.
//    done=1, err=1 at T+1. No ssb, coe_load or sel_o activity.
//  abort=1 at any non-IDLE edge: next cycle state IDLE, all ssb=1, sdi=0.
//    No coe_load, no done. sel_o unchanged; the slave keeps its prior coefficients.
//  abort in IDLE: no effect, and cfg_ready=0 that cycle, so abort wins over a simultaneous accept.
//  abort during the LOAD-visible cycle: the pulse already issued stands; DONE is suppressed.
//  Mid-op reset behaves as reset; partial words are discarded.
//  At most one ssb bit is low in any cycle. coe_load is one-hot or zero.
// TESTING
//  1. Reset, then slave=2, coe re0..im2=0x001,0x002,0x004,0x3FF,0x200,0x155, sel=6'h2A, accept T:
//     ssb[2] low at T+1,3,5,7,9,11, sdi=0x100001,0x110002,0x120004,0x1303FF,0x140200,0x150155;
//     coe_load=4'b0100 and sel_o[17:12]=0x2A at T+13; done T+14; ready T+15.
//  2. slave=7 with NUM_SLAVES=4 -> done=1, err=1 at T+1; ssb stays 4'hF; coe_load stays 0; sel_o unchanged.
//  3. abort at T+6 in test 1 -> from T+7 ssb=4'hF, sdi=0; no coe_load, no done; cfg_ready=1 at T+7.
//  4. Back-to-back requests, cfg_valid held high with a second request to slave 0:
//     second accepted at T+15; its first word at T+16; sel_o[17:12] keeps 0x2A.
//  5. rst low at T+4 -> next cycle all outputs at reset values, including sel_o=0; cfg_ready=1 first cycle after rst high.
//  6. GAP_CYCLES=3 build, test-1 stimulus -> words at T+1,5,...,21; LOAD T+25; done T+26.

Source files
------------

// File: rtl/d_cfir_coe_sequencer.sv
// Coefficient update sequencer for the D-CFIR slave array: serialises one
// 6-coefficient request onto the shared sdi bus, then loads the target slave.
//
// state  | meaning
// IDLE   | waiting for a request; cfg_ready may be high
// WORD   | one sdi word on the bus, target ssb low
// GAP    | inter-word idle, all ssb high (GAP_CYCLES long)
// LOAD   | coe_load pulse and sel_o update for the target slave
// DONE   | done pulse (err also high for an out-of-range slave)
module d_cfir_coe_sequencer #(
   parameter int NUM_SLAVES = 4,
   parameter int COE_W      = 10,
   parameter int GAP_CYCLES = 1
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [3:0]              cfg_slave,
   input  logic [6*COE_W-1:0]      cfg_coe,
   input  logic [5:0]              cfg_sel,
   input  logic                    abort,
   output logic [NUM_SLAVES-1:0]   ssb,
   output logic [22:0]             sdi,
   output logic [NUM_SLAVES-1:0]   coe_load,
   output logic [6*NUM_SLAVES-1:0] sel_o,
   output logic                    done,
   output logic                    err
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WORD, S_GAP, S_LOAD, S_DONE} state_t;

   state_t               state, state_n;
   logic [2:0]           idx, idx_n;
   logic [GW-1:0]        gap_cnt, gap_cnt_n;
   logic [3:0]           slave_q, slave_n;
   logic [6*COE_W-1:0]   coe_q, coe_n;
   logic [5:0]           sel_q, sel_n;

   logic [NUM_SLAVES-1:0]   ssb_n, load_n;
   logic [22:0]             sdi_n;
   logic [6*NUM_SLAVES-1:0] sel_o_n;
   logic                    done_n, err_n;
   logic                    accept, bad_slave;

   assign cfg_ready = (state == S_IDLE) & rst & ~abort;
   assign accept    = cfg_valid & cfg_ready;
   assign bad_slave = {1'b0, cfg_slave} >= 5'(NUM_SLAVES);

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      gap_cnt_n = gap_cnt;
      slave_n   = slave_q;
      coe_n     = coe_q;
      sel_n     = sel_q;
      err_n     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               slave_n = cfg_slave;
               coe_n   = cfg_coe;
               sel_n   = cfg_sel;
               idx_n   = 3'd0;
               if (bad_slave) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else begin
                  state_n = S_WORD;
               end
            end
         end
         S_WORD: begin
            state_n   = S_GAP;
            gap_cnt_n = GW'(GAP_CYCLES - 1);
         end
         S_GAP: begin
            if (gap_cnt == '0) begin
               if (idx == 3'd5) begin
                  state_n = S_LOAD;
               end else begin
                  state_n = S_WORD;
                  idx_n   = idx + 3'd1;
               end
            end else begin
               gap_cnt_n = gap_cnt - GW'(1);
            end
         end
         S_LOAD:  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // abort drops straight back to IDLE; an already-issued load pulse stands
      if (abort && state != S_IDLE) state_n = S_IDLE;
   end

   // outputs are registered, so they are decoded from the next state
   always_comb begin
      ssb_n   = '1;
      sdi_n   = '0;
      load_n  = '0;
      sel_o_n = sel_o;
      done_n  = (state_n == S_DONE);
      if (state_n == S_WORD) begin
         for (int i = 0; i < NUM_SLAVES; i++)
            if (slave_n == 4'(i)) ssb_n[i] = 1'b0;
         sdi_n = {slave_n, idx_n, 16'(coe_n[int'(idx_n)*COE_W +: COE_W])};
      end
      if (state_n == S_LOAD) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_n == 4'(i)) begin
               load_n[i]        = 1'b1;
               sel_o_n[6*i +: 6] = sel_n;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         gap_cnt  <= '0;
         slave_q  <= '0;
         coe_q    <= '0;
         sel_q    <= '0;
         ssb      <= '1;
         sdi      <= '0;
         coe_load <= '0;
         sel_o    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         gap_cnt  <= gap_cnt_n;
         slave_q  <= slave_n;
         coe_q    <= coe_n;
         sel_q    <= sel_n;
         ssb      <= ssb_n;
         sdi      <= sdi_n;
         coe_load <= load_n;
         sel_o    <= sel_o_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

endmodule
